// File: rtl/hashcheck_initiator.sv
// hashcheck_initiator: serialises target-hash loads and candidate checks onto a hash-checker
// handshake. Define HASHCHECK_TIMEOUT_EN to add a resultrdy watchdog with a sticky ERR state.
module hashcheck_initiator #(
    parameter int MAX_HASHES     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [127:0] load_hash,
    output logic         load_ready,
    input  logic         cand_valid,
    input  logic [127:0] cand_hash,
    output logic         cand_ready,
    output logic         newrdy,
    output logic         checkrdy,
    output logic [127:0] hash,
    input  logic         resultrdy,
    input  logic         matchfound,
    output logic         res_valid,
    output logic         res_match,
    output logic [127:0] res_hash,
    output logic [7:0]   loaded_count,
    output logic         full
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_HASHES);

    if (MAX_HASHES < 1 || MAX_HASHES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("hashcheck_initiator: MAX_HASHES must be 1..255 and TIMEOUT_CYCLES >= 1");
    end

`ifdef HASHCHECK_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, LOAD_REQ, CHECK_REQ, WAIT_RES, DRAIN, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD_REQ, CHECK_REQ, WAIT_RES, DRAIN} state_t;
`endif

    state_t state_q;
    state_t state_d;
    logic   is_check_q;
    logic   res_seen;

    // Only the first resultrdy cycle of a transaction counts; DRAIN absorbs the rest.
    assign res_seen = (state_q == WAIT_RES) && resultrdy;
    assign full     = (loaded_count == MAX_CNT);

`ifdef HASHCHECK_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;

    assign tmo_hit = (state_q == WAIT_RES) && !resultrdy && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == WAIT_RES) && !resultrdy) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        cand_ready = 1'b0;
        newrdy     = 1'b0;
        checkrdy   = 1'b0;
        case (state_q)
            IDLE: begin
                // Loads win over candidates unless the table is full.
                if (!rst && load_valid && !full) begin
                    load_ready = 1'b1;
                    state_d    = LOAD_REQ;
                end else if (!rst && cand_valid) begin
                    cand_ready = 1'b1;
                    state_d    = CHECK_REQ;
                end
            end
            LOAD_REQ: begin
                newrdy  = 1'b1;
                state_d = WAIT_RES;
            end
            CHECK_REQ: begin
                checkrdy = 1'b1;
                state_d  = WAIT_RES;
            end
            WAIT_RES: begin
                if (resultrdy) begin
                    state_d = DRAIN;
                end
`ifdef HASHCHECK_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ERR;
                end
`endif
            end
            DRAIN: begin
                if (!resultrdy) begin
                    state_d = IDLE;
                end
            end
`ifdef HASHCHECK_TIMEOUT_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash         <= '0;
            res_hash     <= '0;
            is_check_q   <= 1'b0;
            res_valid    <= 1'b0;
            res_match    <= 1'b0;
            loaded_count <= '0;
        end else begin
            res_valid <= 1'b0;
            if (load_ready) begin
                hash       <= load_hash;
                is_check_q <= 1'b0;
            end else if (cand_ready) begin
                hash       <= cand_hash;
                res_hash   <= cand_hash;
                is_check_q <= 1'b1;
            end
            if (res_seen) begin
                if (is_check_q) begin
                    res_valid <= 1'b1;
                    res_match <= matchfound;
                end else if (!full) begin
                    loaded_count <= loaded_count + 8'd1;
                end
            end
`ifdef HASHCHECK_TIMEOUT_EN
            // A timed-out check still reports, as a miss, on entry to ERR.
            if (tmo_hit && is_check_q) begin
                res_valid <= 1'b1;
                res_match <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hashcheck_initiator.sv
// Testbench for hashcheck_initiator: checker model on the request side, table vectors,
// directed corner sequences and randomized traffic against a set-based reference model.
module tb_hashcheck_initiator;

    localparam int MAXH = 128;
    localparam int TMO  = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load_valid = 1'b0;
    logic [127:0] load_hash = '0;
    logic         load_ready;
    logic         cand_valid = 1'b0;
    logic [127:0] cand_hash = '0;
    logic         cand_ready;
    logic         newrdy;
    logic         checkrdy;
    logic [127:0] hash;
    logic         resultrdy;
    logic         matchfound;
    logic         res_valid;
    logic         res_match;
    logic [127:0] res_hash;
    logic [7:0]   loaded_count;
    logic         full;

    hashcheck_initiator #(.MAX_HASHES(MAXH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_hash(load_hash), .load_ready(load_ready),
        .cand_valid(cand_valid), .cand_hash(cand_hash), .cand_ready(cand_ready),
        .newrdy(newrdy), .checkrdy(checkrdy), .hash(hash),
        .resultrdy(resultrdy), .matchfound(matchfound),
        .res_valid(res_valid), .res_match(res_match), .res_hash(res_hash),
        .loaded_count(loaded_count), .full(full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Environment state
    int  chk_lat    = 1;
    int  chk_hold   = 1;
    bit  chk_silent = 1'b0;
    bit  chk_busy   = 1'b0;
    bit  chk_tbl[bit [127:0]];
    logic [128:0] res_q[$];
    int n_new = 0, n_chk = 0, n_ld_rdy = 0, n_cd_rdy = 0, n_both = 0;

    // Reference model: the set of hashes accepted since reset
    bit [127:0] ref_tbl[$];
    int         ref_count = 0;

    typedef struct {
        bit           is_load;
        logic [127:0] h;
        int           lat;
        int           hold;
        bit           exp_match;
        int           exp_count;
    } vec_t;
    vec_t vecs[5];

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic bit model_has(input logic [127:0] h);
        foreach (ref_tbl[i]) if (ref_tbl[i] == h) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_load(input logic [127:0] h);
        if (ref_count >= MAXH) return 1'b0;
        ref_count++;
        ref_tbl.push_back(h);
        return 1'b1;
    endfunction

    function automatic void model_clear();
        ref_tbl.delete();
        ref_count = 0;
        chk_tbl.delete();
    endfunction

    // Checker: answers each request after chk_lat cycles, holds resultrdy for chk_hold cycles.
    initial begin : checker_model
        bit         is_new;
        bit [127:0] h;
        resultrdy  = 1'b0;
        matchfound = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && !chk_silent && (newrdy || checkrdy)) begin
                is_new   = newrdy;
                h        = hash;
                chk_busy = 1'b1;
                repeat (chk_lat) @(negedge clk);
                resultrdy  = 1'b1;
                matchfound = !is_new && (chk_tbl.exists(h) != 0);
                if (is_new) chk_tbl[h] = 1'b1;
                repeat (chk_hold) @(negedge clk);
                chk("hash_stable", hash, h);
                resultrdy  = 1'b0;
                matchfound = 1'b0;
                chk_busy   = 1'b0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (res_valid) res_q.push_back({res_match, res_hash});
                if (newrdy) n_new++;
                if (checkrdy) n_chk++;
                if (load_ready) n_ld_rdy++;
                if (cand_ready) n_cd_rdy++;
                if (newrdy && checkrdy) n_both++;
            end
        end
    end

    task automatic wait_done(input string nm);
        int t;
        bit seen;
        t = 0;
        #1;
        while (!chk_busy && t < 10) begin @(negedge clk); #1; t++; end
        seen = chk_busy;
        while (chk_busy && t < 100) begin @(negedge clk); #1; t++; end
        chki({nm, "_done"}, int'(seen && !chk_busy), 1);
        @(negedge clk);
    endtask

    task automatic check_result(input logic [127:0] h, input bit exp_match, input string nm);
        logic [128:0] r;
        chki({nm, "_res_count"}, res_q.size(), 1);
        r = '0;
        if (res_q.size() > 0) r = res_q.pop_front();
        chki({nm, "_res_match"}, int'(r[128]), int'(exp_match));
        chk({nm, "_res_hash"}, r[127:0], h);
        res_q.delete();
    endtask

    task automatic do_load(input logic [127:0] h, input bit exp_acc, input int exp_count,
                           input string nm);
        int ld0, nw0;
        ld0 = n_ld_rdy;
        nw0 = n_new;
        @(negedge clk);
        load_valid = 1'b1;
        load_hash  = h;
        #1;
        chki({nm, "_load_ready"}, int'(load_ready), int'(exp_acc));
        @(negedge clk);
        load_valid = 1'b0;
        if (exp_acc) wait_done(nm);
        else @(negedge clk);
        chki({nm, "_count"}, int'(loaded_count), exp_count);
        chki({nm, "_newrdy_pulses"}, n_new - nw0, int'(exp_acc));
        chki({nm, "_load_ready_pulses"}, n_ld_rdy - ld0, int'(exp_acc));
    endtask

    task automatic do_check(input logic [127:0] h, input bit exp_match, input string nm);
        int ck0;
        ck0 = n_chk;
        @(negedge clk);
        cand_valid = 1'b1;
        cand_hash  = h;
        #1;
        chki({nm, "_cand_ready"}, int'(cand_ready), 1);
        @(negedge clk);
        cand_valid = 1'b0;
        wait_done(nm);
        chki({nm, "_checkrdy_pulses"}, n_chk - ck0, 1);
        check_result(h, exp_match, nm);
    endtask

    task automatic check_zero(input string p);
        chki({p, "_newrdy"}, int'(newrdy), 0);
        chki({p, "_checkrdy"}, int'(checkrdy), 0);
        chki({p, "_load_ready"}, int'(load_ready), 0);
        chki({p, "_cand_ready"}, int'(cand_ready), 0);
        chki({p, "_res_valid"}, int'(res_valid), 0);
        chki({p, "_res_match"}, int'(res_match), 0);
        chki({p, "_full"}, int'(full), 0);
        chk({p, "_hash"}, hash, '0);
        chk({p, "_res_hash"}, res_hash, '0);
        chki({p, "_loaded_count"}, int'(loaded_count), 0);
    endtask

    initial begin : main
        logic [127:0] h;
        logic [127:0] h0;
        int           ld0, t;
        bit           ea;

        vecs[0] = '{1'b1, {16{8'hAA}}, 1, 1, 1'b0, 1};
        vecs[1] = '{1'b1, {16{8'h11}}, 2, 3, 1'b0, 2};
        vecs[2] = '{1'b0, {16{8'h11}}, 3, 1, 1'b1, 2};
        vecs[3] = '{1'b0, {16{8'h22}}, 1, 1, 1'b0, 2};
        vecs[4] = '{1'b0, {16{8'hAA}}, 1, 2, 1'b1, 2};

        // Reset with both request inputs asserted: nothing may be accepted.
        #1;
        rst        = 1'b1;
        load_valid = 1'b1;
        cand_valid = 1'b1;
        #2;
        check_zero("reset");
        load_valid = 1'b0;
        cand_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            chk_lat  = vecs[i].lat;
            chk_hold = vecs[i].hold;
            if (vecs[i].is_load) begin
                void'(model_load(vecs[i].h));
                do_load(vecs[i].h, 1'b1, vecs[i].exp_count, $sformatf("vec%0d", i));
            end else begin
                do_check(vecs[i].h, vecs[i].exp_match, $sformatf("vec%0d", i));
                chki($sformatf("vec%0d_count", i), int'(loaded_count), vecs[i].exp_count);
            end
        end

        // Simultaneous load and candidate of the same hash: a match proves the load went first.
        chk_lat  = 2;
        chk_hold = 1;
        h = {16{8'h5C}};
        void'(model_load(h));
        @(negedge clk);
        load_valid = 1'b1;
        load_hash  = h;
        cand_valid = 1'b1;
        cand_hash  = h;
        #1;
        chki("sim_load_ready", int'(load_ready), 1);
        chki("sim_cand_ready_first", int'(cand_ready), 0);
        @(negedge clk);
        load_valid = 1'b0;
        wait_done("sim_load");
        #1;
        chki("sim_cand_ready_after", int'(cand_ready), 1);
        chki("sim_count", int'(loaded_count), ref_count);
        @(negedge clk);
        cand_valid = 1'b0;
        wait_done("sim_check");
        check_result(h, 1'b1, "sim");

        // Randomized traffic against the set model
        for (int i = 0; i < 40; i++) begin
            chk_lat  = int'($urandom_range(1, 4));
            chk_hold = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 0) begin
                h  = {$urandom, $urandom, $urandom, $urandom};
                ea = model_load(h);
                do_load(h, ea, ref_count, $sformatf("rnd%0d", i));
            end else begin
                if (ref_tbl.size() > 0 && $urandom_range(0, 1) == 1)
                    h = ref_tbl[$urandom_range(0, ref_tbl.size() - 1)];
                else
                    h = {$urandom, $urandom, $urandom, $urandom};
                do_check(h, model_has(h), $sformatf("rnd%0d", i));
            end
        end

        // Reset while a check waits on a silent checker: no result, everything cleared.
        chk_silent = 1'b1;
        @(negedge clk);
        cand_valid = 1'b1;
        cand_hash  = {16{8'h3D}};
        @(negedge clk);
        cand_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst        = 1'b0;
        chk_silent = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #3;
        chki("midrst_no_result", res_q.size(), 0);

        // Fill the table, then offer a load and a candidate together.
        chk_lat  = 1;
        chk_hold = 1;
        for (int i = 0; i < MAXH; i++) begin
            h  = {32'hF0F0_0000 + 32'(i), 96'h1234};
            ea = model_load(h);
            do_load(h, ea, ref_count, $sformatf("fill%0d", i));
        end
        chki("full_flag", int'(full), 1);
        chki("full_count", int'(loaded_count), MAXH);
        h0  = {32'hF0F0_0000, 96'h1234};
        ld0 = n_ld_rdy;
        @(negedge clk);
        load_valid = 1'b1;
        load_hash  = {16{8'h99}};
        cand_valid = 1'b1;
        cand_hash  = h0;
        #1;
        chki("full_load_ready", int'(load_ready), 0);
        chki("full_cand_ready", int'(cand_ready), 1);
        @(negedge clk);
        cand_valid = 1'b0;
        wait_done("full_check");
        check_result(h0, model_has(h0), "full_check");
        repeat (3) @(negedge clk);
        #1;
        chki("full_load_refused", n_ld_rdy - ld0, 0);
        chki("full_count_sat", int'(loaded_count), MAXH);
        load_valid = 1'b0;

`ifdef HASHCHECK_TIMEOUT_EN
        // Silent checker: the check times out, reports a miss, and ERR sticks until reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        res_q.delete();
        chk_silent = 1'b1;
        @(negedge clk);
        cand_valid = 1'b1;
        cand_hash  = {16{8'h77}};
        @(negedge clk);
        cand_valid = 1'b0;
        #1;
        chki("tmo_checkrdy", int'(checkrdy), 1);
        t = 0;
        while (!res_valid && t < 200) begin @(negedge clk); #1; t++; end
        // checkrdy cycle, then TMO cycles of waiting, then the result in the first ERR cycle
        chki("tmo_latency", t, TMO + 1);
        chki("tmo_res_match", int'(res_match), 0);
        chk("tmo_res_hash", res_hash, {16{8'h77}});
        @(negedge clk);
        #1;
        chki("tmo_res_pulse", int'(res_valid), 0);
        ld0 = n_ld_rdy + n_cd_rdy;
        load_valid = 1'b1;
        load_hash  = {16{8'h44}};
        cand_valid = 1'b1;
        cand_hash  = {16{8'h44}};
        repeat (5) @(negedge clk);
        #3;
        chki("err_refuses", n_ld_rdy + n_cd_rdy - ld0, 0);
        load_valid = 1'b0;
        cand_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("err_rst");
        @(negedge clk);
        rst        = 1'b0;
        chk_silent = 1'b0;
        res_q.delete();
        ea = model_load({16{8'h44}});
        do_load({16{8'h44}}, ea, ref_count, "after_err");
`endif

        chki("req_exclusive", n_both, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
